// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: sequencer state enum, opcode-class enum and RV32I major opcodes.
package otter_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    // What the sequencer needs to know about the current instruction.
    typedef enum logic [2:0] {
        CL_LOAD    = 3'd0,
        CL_STORE   = 3'd1,
        CL_ALU     = 3'd2,   // OP, OP-IMM, LUI, AUIPC, JAL, JALR
        CL_BRANCH  = 3'd3,
        CL_MRET    = 3'd4,
        CL_CSR     = 3'd5,
        CL_ILLEGAL = 3'd6
    } op_class_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // SYSTEM with funct3 = 000 is treated as MRET; anything else is a CSR op.
    localparam logic [2:0] F3_PRIV    = 3'b000;

endpackage

// File: rtl/cu_decode.sv
// Opcode classifier for the control-unit sequencer.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
// Ports: opcode/funct3 in (instruction bits [6:0], [14:12]); op_class out.
module cu_decode
    import otter_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CL_ILLEGAL;
        case (opcode)
            OPC_LOAD:   op_class = CL_LOAD;
            OPC_STORE:  op_class = CL_STORE;
            OPC_OP,
            OPC_OPIMM,
            OPC_LUI,
            OPC_AUIPC,
            OPC_JAL,
            OPC_JALR:   op_class = CL_ALU;
            OPC_BRANCH: op_class = CL_BRANCH;
            OPC_SYSTEM: op_class = (funct3 == F3_PRIV) ? CL_MRET : CL_CSR;
            default:    op_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cu_sequencer.sv
// Multi-cycle control sequencer: INIT -> FETCH -> EXEC [-> WB] [-> INTR] -> FETCH.
// Latency: non-load retires 2 cycles after FETCH entry, load 3 (with immediate readies).
// Backpressure: holds in FETCH until imem_ready, holds in WB until dmem_ready.
// Ports: clk/rst (sync, active-high); opcode, funct3, intr, mie, imem_ready,
//        dmem_ready in; rst_out, pc_write, reg_write, mem_rden1/2, mem_we2,
//        csr_we, int_taken, mret_exec, illegal strobes out; instret count out.
module cu_sequencer
    import otter_pkg::*;
#(
    parameter int INTR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        intr,
    input  logic        mie,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        rst_out,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_rden1,
    output logic        mem_rden2,
    output logic        mem_we2,
    output logic        csr_we,
    output logic        int_taken,
    output logic        mret_exec,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t    state_q;
    state_t    state_d;
    op_class_t op_class;
    logic      take_intr;
    logic      retire;
    logic [31:0] instret_q;

    cu_decode u_decode (
        .opcode   (opcode),
        .funct3   (funct3),
        .op_class (op_class)
    );

    // intr only matters at the two instruction-exit points below.
    assign take_intr = (INTR_EN != 0) && intr && mie;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_out   = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            ST_INIT: begin
                rst_out = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                if (imem_ready) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (op_class == CL_LOAD) begin
                    // PC advances only once the load data is written back.
                    mem_rden2 = 1'b1;
                    state_d   = ST_WB;
                end else begin
                    pc_write = 1'b1;
                    state_d  = take_intr ? ST_INTR : ST_FETCH;
                    case (op_class)
                        CL_STORE:   mem_we2 = 1'b1;
                        CL_ALU:     reg_write = 1'b1;
                        CL_MRET:    mret_exec = 1'b1;
                        CL_CSR: begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                        end
                        CL_ILLEGAL: illegal = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_WB: begin
                if (dmem_ready) begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    state_d   = take_intr ? ST_INTR : ST_FETCH;
                end
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
            end
            default: state_d = ST_INIT;
        endcase

        // While reset is held no datapath strobe may fire, whatever the state.
        if (rst) begin
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_rden1 = 1'b0;
            mem_rden2 = 1'b0;
            mem_we2   = 1'b0;
            csr_we    = 1'b0;
            int_taken = 1'b0;
            mret_exec = 1'b0;
            illegal   = 1'b0;
        end
    end

    // The PC write of an interrupt entry is a redirect, not a retirement.
    assign retire = pc_write && ((state_q == ST_EXEC) || (state_q == ST_WB));

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= 32'd0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_cu_sequencer.sv
module tb_cu_sequencer;

    // Strobe vector bit positions.
    localparam int B_RST = 9, B_PC = 8, B_REG = 7, B_RD1 = 6, B_RD2 = 5;
    localparam int B_WE2 = 4, B_CSR = 3, B_INT = 2, B_MRET = 1, B_ILL = 0;

    // Model phases.
    localparam int M_INIT = 0, M_FETCH = 1, M_EXEC = 2, M_WB = 3, M_INTR = 4;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       intr, mie, imem_ready, dmem_ready;

    logic [1:0][9:0]  act;
    logic [1:0][31:0] ir;

    logic r0_rst, r0_pc, r0_reg, r0_rd1, r0_rd2, r0_we2, r0_csr, r0_int, r0_mret, r0_ill;
    logic r1_rst, r1_pc, r1_reg, r1_rd1, r1_rd2, r1_we2, r1_csr, r1_int, r1_mret, r1_ill;

    cu_sequencer #(.INTR_EN(1)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .intr(intr), .mie(mie),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .rst_out(r0_rst), .pc_write(r0_pc), .reg_write(r0_reg), .mem_rden1(r0_rd1),
        .mem_rden2(r0_rd2), .mem_we2(r0_we2), .csr_we(r0_csr), .int_taken(r0_int),
        .mret_exec(r0_mret), .illegal(r0_ill), .instret(ir[0])
    );

    cu_sequencer #(.INTR_EN(0)) dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .intr(intr), .mie(mie),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .rst_out(r1_rst), .pc_write(r1_pc), .reg_write(r1_reg), .mem_rden1(r1_rd1),
        .mem_rden2(r1_rd2), .mem_we2(r1_we2), .csr_we(r1_csr), .int_taken(r1_int),
        .mret_exec(r1_mret), .illegal(r1_ill), .instret(ir[1])
    );

    assign act[0] = {r0_rst, r0_pc, r0_reg, r0_rd1, r0_rd2, r0_we2, r0_csr, r0_int, r0_mret, r0_ill};
    assign act[1] = {r1_rst, r1_pc, r1_reg, r1_rd1, r1_rd2, r1_we2, r1_csr, r1_int, r1_mret, r1_ill};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    int          cur_ph  [2];
    int          nxt_ph  [2];
    logic [31:0] cur_cnt [2];
    logic [31:0] nxt_cnt [2];
    bit          cur_vld [2];
    bit          nxt_vld [2];
    bit          ien     [2];

    initial begin
        ien[0] = 1'b1;
        ien[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cur_ph[d] = M_INIT; nxt_ph[d] = M_INIT;
            cur_vld[d] = 1'b0;  nxt_vld[d] = 1'b0;
            cur_cnt[d] = 32'd0; nxt_cnt[d] = 32'd0;
        end
    end

    // Expected strobes for a given phase under the current inputs.
    function automatic logic [9:0] m_out(int ph);
        logic [9:0] o;
        o = 10'd0;
        case (ph)
            M_INIT:  o[B_RST] = 1'b1;
            M_FETCH: o[B_RD1] = 1'b1;
            M_EXEC: begin
                case (opcode)
                    7'b0000011: o[B_RD2] = 1'b1;
                    7'b0100011: begin o[B_WE2] = 1'b1; o[B_PC] = 1'b1; end
                    7'b0110011, 7'b0010011, 7'b0110111,
                    7'b0010111, 7'b1101111, 7'b1100111: begin o[B_REG] = 1'b1; o[B_PC] = 1'b1; end
                    7'b1100011: o[B_PC] = 1'b1;
                    7'b1110011: begin
                        o[B_PC] = 1'b1;
                        if (funct3 == 3'b000) o[B_MRET] = 1'b1;
                        else begin o[B_CSR] = 1'b1; o[B_REG] = 1'b1; end
                    end
                    default: begin o[B_ILL] = 1'b1; o[B_PC] = 1'b1; end
                endcase
            end
            M_WB:    if (dmem_ready) begin o[B_REG] = 1'b1; o[B_PC] = 1'b1; end
            M_INTR:  begin o[B_INT] = 1'b1; o[B_PC] = 1'b1; end
            default: o = 10'd0;
        endcase
        if (rst) o[8:0] = 9'd0;
        return o;
    endfunction

    function automatic int m_next(int ph, bit en);
        bit trap;
        trap = en && intr && mie;
        if (rst) return M_INIT;
        case (ph)
            M_INIT:  return M_FETCH;
            M_FETCH: return imem_ready ? M_EXEC : M_FETCH;
            M_EXEC:  return (opcode == 7'b0000011) ? M_WB : (trap ? M_INTR : M_FETCH);
            M_WB:    return dmem_ready ? (trap ? M_INTR : M_FETCH) : M_WB;
            default: return M_FETCH;
        endcase
    endfunction

    // Compare, then compute the state the coming rising edge will produce.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [9:0] e;
            logic [9:0] msk;
            e   = m_out(cur_ph[d]);
            msk = rst ? 10'h1FF : 10'h3FF;
            if (cur_vld[d]) begin
                checks++;
                if ((act[d] & msk) !== (e & msk)) begin
                    errors++;
                    $display("FAIL strobes dut%0d t=%0t: got %b expected %b", d, $time, act[d] & msk, e & msk);
                end
                checks++;
                if (ir[d] !== cur_cnt[d]) begin
                    errors++;
                    $display("FAIL instret dut%0d t=%0t: got %h expected %h", d, $time, ir[d], cur_cnt[d]);
                end
            end
            nxt_ph[d] = m_next(cur_ph[d], ien[d]);
            if (rst) begin
                nxt_cnt[d] = 32'd0;
                nxt_vld[d] = 1'b1;
            end else if (e[B_PC] && (cur_ph[d] == M_EXEC || cur_ph[d] == M_WB)) begin
                nxt_cnt[d] = cur_cnt[d] + 32'd1;
            end else begin
                nxt_cnt[d] = cur_cnt[d];
            end
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            cur_ph[d]  = nxt_ph[d];
            cur_cnt[d] = nxt_cnt[d];
            cur_vld[d] = nxt_vld[d];
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic sync_in();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wait_ph(input int ph, input string nm);
        int n;
        n = 0;
        while (cur_ph[0] != ph && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL timeout_%s: phase %0d not reached, still %0d", nm, ph, cur_ph[0]);
        end
    endtask

    logic [31:0] cnt_snap;

    initial begin
        rst = 1'b1; opcode = 7'b0110011; funct3 = 3'd0;
        intr = 1'b0; mie = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;

        // Reset state.
        tick();
        chk("reset_instret", ir[0], 32'd0);
        chk("reset_pc_write", {31'd0, r0_pc}, 32'd0);
        tick();

        // ALU op straight through: INIT, FETCH, EXEC, instret=1.
        sync_in(); rst = 1'b0; imem_ready = 1'b1;
        tick(); chk("alu_init_rst_out", {31'd0, r0_rst}, 32'd1);
        tick(); chk("alu_fetch_rden1", {31'd0, r0_rd1}, 32'd1);
        tick(); chk("alu_exec_reg_pc", {30'd0, r0_reg, r0_pc}, 32'd3);
        tick(); chk("alu_instret_1", ir[0], 32'd1);

        // Load with dmem_ready low for 3 WB cycles.
        sync_in(); opcode = 7'b0000011; dmem_ready = 1'b0;
        tick(); wait_ph(M_WB, "load_wb");
        chk("wb_hold1", {22'd0, act[0]}, 32'd0);
        tick(); chk("wb_hold2", {22'd0, act[0]}, 32'd0);
        tick(); chk("wb_hold3", {22'd0, act[0]}, 32'd0);
        sync_in(); dmem_ready = 1'b1;
        tick(); chk("wb_done_reg_pc", {30'd0, r0_reg, r0_pc}, 32'd3);

        // Branch with interrupt pending: EXEC, INTR, FETCH; INTR_EN=0 copy ignores it.
        sync_in(); opcode = 7'b1100011; intr = 1'b1; mie = 1'b1;
        tick(); wait_ph(M_EXEC, "br_exec");
        chk("br_exec_pc_only", {22'd0, act[0]}, 32'h100);
        cnt_snap = cur_cnt[0];
        tick();
        chk("intr_taken", {30'd0, r0_int, r0_pc}, 32'd3);
        chk("intr_en0_no_trap", {31'd0, r1_int}, 32'd0);
        tick();
        chk("intr_then_fetch", {31'd0, r0_rd1}, 32'd1);
        chk("intr_instret_plus1", ir[0], cnt_snap + 32'd1);

        // mie low: no trap; MRET then CSR op.
        sync_in(); mie = 1'b0; opcode = 7'b1110011; funct3 = 3'b000;
        tick(); wait_ph(M_EXEC, "mret_exec");
        chk("mret_pulse", {30'd0, r0_mret, r0_pc}, 32'd3);
        tick(); chk("mie0_fetch_not_intr", {30'd0, r0_int, r0_rd1}, 32'd1);
        sync_in(); funct3 = 3'b010;
        tick(); wait_ph(M_EXEC, "csr_exec");
        chk("csr_we_reg_pc", {29'd0, r0_csr, r0_reg, r0_pc}, 32'd7);

        // Illegal opcode.
        sync_in(); opcode = 7'b1111111; funct3 = 3'b000; intr = 1'b0;
        tick(); wait_ph(M_EXEC, "ill_exec");
        chk("illegal_ill_pc_reg", {29'd0, r0_ill, r0_pc, r0_reg}, 32'd6);

        // Reset during a stalled WB.
        sync_in(); opcode = 7'b0000011; dmem_ready = 1'b0;
        tick(); wait_ph(M_WB, "rst_wb");
        tick();
        sync_in(); rst = 1'b1;
        tick(); chk("rst_strobes_zero", {23'd0, act[0][8:0]}, 32'd0);
        sync_in(); rst = 1'b0; opcode = 7'b0110011; dmem_ready = 1'b1;
        tick();
        chk("rst_wb_init", {31'd0, r0_rst}, 32'd1);
        chk("rst_wb_instret0", ir[0], 32'd0);

        // instret wrap.
        tick(); wait_ph(M_FETCH, "wrap_fetch");
        force dut0.instret_q = 32'hFFFF_FFFD;
        cur_cnt[0] = 32'hFFFF_FFFD;
        nxt_cnt[0] = 32'hFFFF_FFFD;
        #1;
        release dut0.instret_q;
        repeat (5) tick();
        chk("wrap_max", ir[0], 32'hFFFF_FFFF);
        tick();
        chk("wrap_zero", ir[0], 32'h0000_0000);

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/cu_sequencer.md
CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 Parameter INTR_EN, default 1; 0 SHALL tie interrupt acceptance off (INTR state unreachable).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  7  instruction bits [6:0] of current instruction.
REQ-005 funct3  input  3  instruction bits [14:12].
REQ-006 intr  input  1  external interrupt request, level.
REQ-007 mie  input  1  interrupt-enable from CSR file.
REQ-008 imem_ready  input  1  instruction fetch data valid.
REQ-009 dmem_ready  input  1  load data valid.
REQ-010 rst_out  output  1  resets PC register and register file.
REQ-011 pc_write  output  1  load enable for PC register.
REQ-012 reg_write, mem_rden1, mem_rden2, mem_we2, csr_we  output  1 each  datapath strobes.
REQ-013 int_taken, mret_exec, illegal  output  1 each  trap/return/illegal-opcode pulses.
REQ-014 instret  output  32  retired-instruction count.

Function
REQ-015 States SHALL be INIT, FETCH, EXEC, WB, INTR; outputs except instret SHALL be combinational from state and inputs.
REQ-016 INIT: rst_out=1, all other strobes 0; next state FETCH unconditionally.
REQ-017 FETCH: mem_rden1=1; remain in FETCH while imem_ready=0; go to EXEC on the cycle imem_ready=1.
REQ-018 EXEC, LOAD (0000011): mem_rden2=1, pc_write=0; next WB.
REQ-019 EXEC, STORE (0100011): mem_we2=1, pc_write=1.
REQ-020 EXEC, OP/OP-IMM/LUI/AUIPC/JAL/JALR: reg_write=1, pc_write=1.
REQ-021 EXEC, BRANCH (1100011): pc_write=1 only.
REQ-022 EXEC, SYSTEM (1110011): funct3=000 -> mret_exec=1, pc_write=1; funct3!=000 -> csr_we=1, reg_write=1, pc_write=1.
REQ-023 EXEC, any other opcode: illegal=1, pc_write=1, no register/memory/CSR write.
REQ-024 WB: all strobes 0 while dmem_ready=0 (hold); on dmem_ready=1 reg_write=1, pc_write=1.
REQ-025 Exit from EXEC (non-load) and completing WB SHALL go to INTR if INTR_EN && intr && mie, else FETCH.
REQ-026 intr SHALL be sampled only at REQ-025 exit points; intr changes in FETCH, INTR or stalled WB SHALL have no effect.
REQ-027 INTR: int_taken=1, pc_write=1 for exactly one cycle; next FETCH.
REQ-028 instret SHALL increment by 1 on each pc_write in EXEC or WB (not INTR), wrap 0xFFFFFFFF -> 0.
REQ-029 Latency: non-load with imem_ready immediate SHALL retire in 2 cycles; load with both readies immediate in 3.

Reset
REQ-030 rst=1 SHALL force next state INIT and instret=0 at the next edge, from any state including stalled FETCH/WB.
REQ-031 During any cycle with rst=1 all strobe outputs SHALL be 0.
REQ-032 First cycle after rst deasserts SHALL be INIT (rst_out=1).

Structure
REQ-033 State enum and opcode constants SHALL live in shared package otter_pkg.
REQ-034 Opcode classification SHALL be one combinational sub-module cu_decode; FSM and instret counter stay in cu_sequencer.

Verification
REQ-035 Reset then opcode=0110011, imem_ready=1 -> INIT, FETCH, EXEC with reg_write=1, pc_write=1; instret=1.
REQ-036 opcode=0000011, dmem_ready low 3 cycles -> WB held 3 cycles all strobes 0, 4th cycle reg_write=1, pc_write=1.
REQ-037 opcode=1100011, intr=1, mie=1 -> EXEC pc_write=1, next INTR int_taken=1, then FETCH; instret +1 only.
REQ-038 intr=1, mie=0 or INTR_EN=0 -> no INTR entry; opcode=1110011 funct3=000 -> mret_exec=1.
REQ-039 opcode=1111111 -> illegal=1, pc_write=1, reg_write=0; rst asserted mid-WB stall -> INIT next, instret=0.
REQ-040 instret preloaded near 0xFFFFFFFF via repeated retirements -> wraps to 0x00000000.
